// File: rtl/obuf_drain_ctrl.sv
// Output-buffer sequencer: captures a finished tile, then drains it row by row over valid/ready.
// Define OBUF_CTRL_PERF_EN to build the saturating drain-stall counter behind stall_cnt_o.
module obuf_drain_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tile_done_i,
    input  logic                 out_ready_i,
    output logic                 load_en_o,
    output logic                 out_en_o,
    output logic                 out_valid_o,
    output logic [$clog2(N)-1:0] out_row_o,
    output logic                 busy_o,
    output logic                 tile_ack_o,
    output logic                 overrun_o,
    output logic [CW-1:0]        stall_cnt_o
);

    localparam int unsigned RW = $clog2(N);
    localparam logic [RW-1:0] LastIdx = RW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StDrain,
        StAck
    } state_e;

    state_e        state_q;
    logic [RW-1:0] ld_cnt_q;
    logic [RW-1:0] out_row_q;
    logic          load_en_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          tile_ack_q;
    logic          overrun_q;

    // Strobes are registered alongside the state so they line up with it cycle for cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ld_cnt_q    <= '0;
            out_row_q   <= '0;
            load_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tile_ack_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (tile_done_i && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tile_done_i) begin
                        state_q   <= StLoad;
                        ld_cnt_q  <= '0;
                        load_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_cnt_q == LastIdx) begin
                        state_q   <= StSettle;
                        ld_cnt_q  <= '0;
                        load_en_q <= 1'b0;
                    end else begin
                        ld_cnt_q <= ld_cnt_q + RW'(1);
                    end
                end
                StSettle: begin
                    state_q     <= StDrain;
                    out_valid_q <= 1'b1;
                end
                StDrain: begin
                    if (out_ready_i) begin
                        if (out_row_q == LastIdx) begin
                            state_q     <= StAck;
                            out_row_q   <= '0;
                            out_valid_q <= 1'b0;
                            tile_ack_q  <= 1'b1;
                        end else begin
                            out_row_q <= out_row_q + RW'(1);
                        end
                    end
                end
                StAck: begin
                    state_q    <= StIdle;
                    tile_ack_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // out_valid_q is high exactly in DRAIN, so this never shifts an unaccepted row.
    assign out_en_o    = out_valid_q & out_ready_i;
    assign load_en_o   = load_en_q;
    assign out_valid_o = out_valid_q;
    assign out_row_o   = out_row_q;
    assign busy_o      = busy_q;
    assign tile_ack_o  = tile_ack_q;
    assign overrun_o   = overrun_q;

`ifdef OBUF_CTRL_PERF_EN
    logic [CW-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == StDrain) && !out_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + CW'(1);
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Directed bench for obuf_drain_ctrl (N=4, CW=4): table-driven nominal tile plus corner sequences.
module tb_obuf_drain_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;
`ifdef OBUF_CTRL_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tile_done;
    logic          out_ready;
    logic          load_en;
    logic          out_en;
    logic          out_valid;
    logic [1:0]    out_row;
    logic          busy;
    logic          tile_ack;
    logic          overrun;
    logic [CW-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    obuf_drain_ctrl #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_done_i(tile_done),
        .out_ready_i(out_ready),
        .load_en_o  (load_en),
        .out_en_o   (out_en),
        .out_valid_o(out_valid),
        .out_row_o  (out_row),
        .busy_o     (busy),
        .tile_ack_o (tile_ack),
        .overrun_o  (overrun),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // One nominal tile, offset 0 = cycle tile_done is driven, out_ready held high.
    typedef struct {
        logic       td;
        logic       le;
        logic       oe;
        logic       ov;
        logic [1:0] row;
        logic       busy;
        logic       ack;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    // Drive inputs just after a rising edge, then sample at the falling edge.
    task automatic step(input logic td, input logic rdy, input logic r);
        @(posedge clk);
        #1;
        cyc++;
        tile_done = td;
        out_ready = rdy;
        rst       = r;
        @(negedge clk);
    endtask

    task automatic chk_outs(input logic le, input logic oe, input logic ov, input logic [1:0] row,
                            input logic bz, input logic ack, input logic ovr);
        chk("load_en", 32'(load_en), 32'(le));
        chk("out_en", 32'(out_en), 32'(oe));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_row", 32'(out_row), 32'(row));
        chk("busy", 32'(busy), 32'(bz));
        chk("tile_ack", 32'(tile_ack), 32'(ack));
        chk("overrun", 32'(overrun), 32'(ovr));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_outs(0, 0, 0, 0, 0, 0, 0);
        chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
        cyc = -1;
    endtask

    task automatic idle_until(input int t, input logic ovr);
        while (cyc < t - 1) begin
            step(1'b0, 1'b1, 1'b0);
            chk_outs(0, 0, 0, 0, 0, 0, ovr);
        end
    endtask

    // Play table rows 0..last; extra_td injects a second tile_done at that offset.
    task automatic run_tile(input int last, input int extra_td, input logic ovr0);
        for (int i = 0; i <= last; i++) begin
            logic ovr_exp;
            ovr_exp = ovr0 | ((extra_td >= 0) && (i > extra_td));
            step(tbl[i].td | (i == extra_td), 1'b1, 1'b0);
            chk_outs(tbl[i].le, tbl[i].oe, tbl[i].ov, tbl[i].row, tbl[i].busy, tbl[i].ack,
                     ovr_exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        tile_done = 1'b0;
        out_ready = 1'b0;

        tbl[0]  = '{td: 1, le: 0, oe: 0, ov: 0, row: 0, busy: 0, ack: 0};
        tbl[1]  = '{td: 0, le: 1, oe: 0, ov: 0, row: 0, busy: 1, ack: 0};
        tbl[2]  = '{td: 0, le: 1, oe: 0, ov: 0, row: 0, busy: 1, ack: 0};
        tbl[3]  = '{td: 0, le: 1, oe: 0, ov: 0, row: 0, busy: 1, ack: 0};
        tbl[4]  = '{td: 0, le: 1, oe: 0, ov: 0, row: 0, busy: 1, ack: 0};
        tbl[5]  = '{td: 0, le: 0, oe: 0, ov: 0, row: 0, busy: 1, ack: 0};
        tbl[6]  = '{td: 0, le: 0, oe: 1, ov: 1, row: 0, busy: 1, ack: 0};
        tbl[7]  = '{td: 0, le: 0, oe: 1, ov: 1, row: 1, busy: 1, ack: 0};
        tbl[8]  = '{td: 0, le: 0, oe: 1, ov: 1, row: 2, busy: 1, ack: 0};
        tbl[9]  = '{td: 0, le: 0, oe: 1, ov: 1, row: 3, busy: 1, ack: 0};
        tbl[10] = '{td: 0, le: 0, oe: 0, ov: 0, row: 0, busy: 1, ack: 1};

        // Nominal tile at 10: ack at 20, idle at 21.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(10, -1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 0, 0, 0);
        chk("stall_nominal", 32'(stall_cnt), 32'd0);

        // out_ready low in 17-18: row holds at 1, ack moves to 22.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(6, -1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_outs(0, 0, 1, 1, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_outs(0, 0, 1, 1, 1, 0, 0);
        for (int r = 1; r < 4; r++) begin
            step(1'b0, 1'b1, 1'b0);
            chk_outs(0, 1, 1, 2'(r), 1, 0, 0);
        end
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 1, 1, 0);
        chk("stall_two", 32'(stall_cnt), Perf ? 32'd2 : 32'd0);

        // Second tile_done at 13 is dropped and sets overrun; overrun sticks afterwards.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(10, 3, 1'b0);
        idle_until(25, 1'b1);

        // Back-to-back: second tile_done at 21 lands on the return to IDLE.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(10, -1, 1'b0);
        run_tile(10, -1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 0, 0, 0);

        // Reset at 17 during DRAIN, then a clean tile at 20.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(6, -1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk_outs(0, 1, 1, 1, 1, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 0, 0, 0);
        idle_until(20, 1'b0);
        run_tile(10, -1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 0, 0, 0);

        // 20 stalled DRAIN cycles: 4-bit counter saturates at 15; out_valid must not drop.
        do_reset();
        idle_until(10, 1'b0);
        run_tile(5, -1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk_outs(0, 0, 1, 0, 1, 0, 0);
        end
        for (int r = 0; r < 4; r++) begin
            step(1'b0, 1'b1, 1'b0);
            chk_outs(0, 1, 1, 2'(r), 1, 0, 0);
        end
        chk("stall_sat", 32'(stall_cnt), Perf ? 32'd15 : 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs(0, 0, 0, 0, 1, 1, 0);
        chk("stall_sat_hold", 32'(stall_cnt), Perf ? 32'd15 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
